// File: rtl/dmem_lsu.sv
// Load/store unit between the core and a word-organised data memory bank.
// Optional LSU_STATS_EN adds saturating load/store/error counters.
module dmem_lsu #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state, state_nxt;
    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, word_q;
    logic [2:0]        rd_cnt;
    logic              req_err, rd_last, accept;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val, merged;

    assign accept  = (state == IDLE) && req_valid;
    assign rd_last = (rd_cnt == 3'(RD_WAIT - 1));

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rd_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_err;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_cnt  <= '0;
            end
            if (state == RD) begin
                if (rd_last) word_q <= mem_rdata;
                else         rd_cnt <= rd_cnt + 3'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                if (req_err)                         state_nxt = RESP;
                else if (req_we && req_size == 2'b10) state_nxt = WR;
                else                                 state_nxt = RD;
            end
            RD:   if (rd_last) state_nxt = we_q ? WR : RESP;
            WR:   state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Little-endian lane extraction and merge, both from the captured word.
    always_comb begin
        lane_b   = word_q[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = addr_q[1] ? word_q[31:16] : word_q[15:0];
        load_val = word_q;
        merged   = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merged   = word_q;
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merged   = addr_q[1] ? {wdata_q[15:0], word_q[15:0]}
                                     : {word_q[31:16], wdata_q[15:0]};
            end
            default: begin
                load_val = word_q;
                merged   = wdata_q;
            end
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = (state == RESP) && err_q;
        resp_rdata = ((state == RESP) && !err_q && !we_q) ? load_val : '0;
        mem_read   = (state == RD);
        mem_write  = (state == WR);
        mem_addr   = (state != IDLE) ? addr_q[ADDR_W+1:2] : '0;
        mem_wdata  = (state == WR) ? merged : '0;
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (we_q) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu with a behavioural word bank.
module tb_dmem_lsu;

    localparam int unsigned ADDR_W = 8;
`ifdef LSU_STATS_EN
    localparam int unsigned RW = 3;
`else
    localparam int unsigned RW = 1;
`endif
    localparam int LD = 1 + RW;
    localparam int SS = 2 + RW;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]        req_size;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid, resp_err, mem_read, mem_write;
    logic [31:0]       resp_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
`ifdef LSU_STATS_EN
    logic [15:0]       stat_loads, stat_stores, stat_errs;
`endif

    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    always #5 clk = ~clk;

    dmem_lsu #(.ADDR_W(ADDR_W), .RD_WAIT(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef LSU_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
            miscompares++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat, rdc, wrc;
        logic got;
        logic [31:0] wd, rd;
        logic er;
        string tag;
        tag = $sformatf("v%0d", idx);
        lat = 1; rdc = 0; wrc = 0; got = 1'b0; wd = '0; rd = '0; er = 1'b0;
        @(negedge clk);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
        req_addr = v.addr; req_wdata = v.wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read) rdc++;
            if (mem_write) begin wrc++; wd = mem_wdata; end
            if (resp_valid) begin got = 1'b1; rd = resp_rdata; er = resp_err; break; end
            lat++;
        end
        vectors++;
        if (!got) begin
            $display("FAIL %s.timeout: got no resp_valid expected one within 20 cycles", tag);
            miscompares++;
        end else begin
            chk({tag, ".rdata"}, rd, v.exp_rdata);
            chk({tag, ".err"}, {31'd0, er}, {31'd0, v.exp_err});
            chk({tag, ".lat"}, lat, v.exp_lat);
            chk({tag, ".rdcyc"}, rdc, v.exp_rd);
            chk({tag, ".wrcyc"}, wrc, v.exp_wr);
            if (v.exp_wr != 0) chk({tag, ".wdata"}, wd, v.exp_wdata);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"},  {31'd0, req_ready},  32'd1);
        chk({tag, ".rvalid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, ".rdata"},  resp_rdata, 32'd0);
        chk({tag, ".err"},    {31'd0, resp_err},   32'd0);
        chk({tag, ".mrd"},    {31'd0, mem_read},   32'd0);
        chk({tag, ".mwr"},    {31'd0, mem_write},  32'd0);
        chk({tag, ".maddr"},  {24'd0, mem_addr},   32'd0);
        chk({tag, ".mwdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        int n_ld, n_st, n_er, wrs;
        for (int i = 0; i < 256; i++) mem[i] = i;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        //          we  size  uns  addr     wdata         exp_rdata    err lat rd  wr exp_wdata
        vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h014, 32'h0,        32'h00000005, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 10'h00C, 32'h123480F0, 32'h0,        1'b0, 2,  0,  1, 32'h123480F0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 10'h00C, 32'h0,        32'hFFFFFFF0, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 10'h00D, 32'h0,        32'h00000080, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 10'h00E, 32'h0,        32'h00001234, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 10'h00C, 32'h0,        32'hFFFF80F0, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 10'h00D, 32'hFFFFFFAB, 32'h0,        1'b0, SS, RW, 1, 32'h1234ABF0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h00C, 32'h0,        32'h1234ABF0, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 10'h011, 32'h0,        32'h0,        1'b1, 1,  0,  0, 32'h0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 10'h000, 32'h0,        32'h0,        1'b1, 1,  0,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 10'h002, 32'hDEADBEEF, 32'h0,        1'b1, 1,  0,  0, 32'h0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 10'h012, 32'h0000BEEF, 32'h0,        1'b0, SS, RW, 1, 32'hBEEF0004});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,        32'h0000BEEF, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,        32'hFFFFFFBE, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 10'h3FC, 32'h0,        32'h000000FF, 1'b0, LD, RW, 0, 32'h0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 10'h3FF, 32'h0,        32'h00000000, 1'b0, LD, RW, 0, 32'h0});

        repeat (2) @(negedge clk);
        chk_idle("rst");
        vectors++;
`ifdef LSU_STATS_EN
        chk("rst.stat_loads", {16'd0, stat_loads}, 32'd0);
`endif
        rst_n = 1'b1;

        n_ld = 0; n_st = 0; n_er = 0;
        foreach (vecs[i]) begin
            run_vec(i, vecs[i]);
            if (vecs[i].exp_err) n_er++;
            else if (vecs[i].we) n_st++;
            else n_ld++;
        end
        @(negedge clk);
`ifdef LSU_STATS_EN
        vectors++;
        chk("stat_loads",  {16'd0, stat_loads},  n_ld);
        chk("stat_stores", {16'd0, stat_stores}, n_st);
        chk("stat_errs",   {16'd0, stat_errs},   n_er);
`endif

        // Reset during the read phase of a sub-word store must abort the write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 10'h020; req_wdata = 32'h00000055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        vectors++;
        chk("midrst.rd_before", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
`ifdef LSU_STATS_EN
        chk("midrst.stat_stores", {16'd0, stat_stores}, 32'd0);
`endif
        wrs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_write) wrs++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_write) wrs++;
        end
        chk("midrst.wrcount", wrs, 0);
        chk("midrst.memword", mem[8], 32'h00000008);
        run_vec(99, '{1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h00000008, 1'b0, LD, RW, 0, 32'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator that sits between the datapath and the word-organised data memory bank. It accepts byte, halfword and word requests from the core over a valid/ready handshake and drives the bank's memread/memwrite/address/writedata/readdata interface. Sub-word loads are extracted and extended from a full word. Sub-word stores are done as read-modify-write, because the bank only writes whole words.

Parameters:
ADDR_W, 8, word-address width of the memory port; the byte address is ADDR_W+2 bits
RD_WAIT, 1, cycles mem_read is held before mem_rdata is captured (legal range 1..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core request valid
req_ready  output  1  LSU can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
req_addr  input  ADDR_W+2  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned or illegal-size request
mem_read  output  1  to bank memread
mem_write  output  1  to bank memwrite
mem_addr  output  ADDR_W  word address, equal to req_addr[ADDR_W+1:2]
mem_wdata  output  32  to bank writedata
mem_rdata  input  32  from bank readdata

Behaviour:
- Reset (async, while rst_n=0): state IDLE. All outputs are 0 except req_ready=1. Internal request registers are cleared.
- Reset mid-operation: return to IDLE immediately. mem_write drops combinationally with the state, so no partial write is issued after reset.
- Handshake: a request is accepted on a rising edge where req_valid and req_ready are both 1. req_ready is 1 only in IDLE. All req_* fields are registered at acceptance.
- Responses have no backpressure. resp_valid is high for exactly one cycle, in state RESP.
- FSM states: IDLE, RD, WR, RESP.
- IDLE -> RESP with err=1 when: size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0. No mem_read or mem_write is issued.
- IDLE -> RD for a load or a sub-word store. IDLE -> WR for a word store.
- RD: mem_read=1 for RD_WAIT cycles. mem_rdata is captured on the last of these edges. Then a load goes to RESP and a store goes to WR.
- WR: mem_write=1 for exactly 1 cycle, then RESP.
- RESP: resp_valid=1, then IDLE. A new request can be accepted on the following cycle.
- mem_addr holds the registered word address outside IDLE and is 0 in IDLE. mem_read, mem_write and mem_wdata are 0 outside RD and WR.
- Byte lanes are little-endian: byte k = word[8k+7:8k], with k=addr[1:0]. Half = word[15:0] if addr[1]=0, else word[31:16].
- Load extension: sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned=1. Word loads are passed unchanged.
- Sub-word store merge: mem_wdata = captured word with only the addressed lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
- Latency from the acceptance edge to resp_valid, with RD_WAIT=1:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle

Optional Feature:
LSU_STATS_EN
- Defined: adds outputs stat_loads, stat_stores and stat_errs, each 16 bits.
  - Each counter increments on the RESP cycle of a completed load, a completed store, or an error respectively.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bank preloaded with mem[i]=i. Load word at byte addr 0x014 -> resp_rdata=0x00000005, resp_err=0, resp_valid 2 cycles after acceptance.
- Store word 0x123480F0 at 0x00C, then:
  - signed byte load at 0x00C -> 0xFFFFFFF0
  - unsigned byte load at 0x00D -> 0x00000080
  - signed half load at 0x00E -> 0x00001234
- Store byte 0xAB at 0x00D (req_wdata=0xFFFFFFAB) -> one mem_read cycle, then one mem_write with mem_wdata=0x1234ABF0. A following word load at 0x00C returns 0x1234ABF0.
- Half load at 0x011, and a request with size=11 -> each gives resp_err=1 and resp_rdata=0 one cycle after acceptance, with no mem_read or mem_write pulse.
- Sub-word store in progress: pull rst_n low during RD -> outputs clear immediately, mem_write never asserts, and the memory word is unchanged.
- With LSU_STATS_EN and RD_WAIT=3: run 2 loads, 1 store and 1 error -> stat_loads=2, stat_stores=1, stat_errs=1. Each load's mem_read stays high for 3 cycles.
